// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the register file.
// Holds the default data width, register count, zero-register index and address width.
package regfile_pkg;

    localparam int WIDTH    = 64;
    localparam int NREGS    = 32;
    localparam int ZERO_REG = 31;
    localparam int ADDR_W   = 5;

    // Storage slot for an architectural index. The zero register has no
    // storage, so indices above it shift down by one.
    function automatic int slot_of(input int idx, input int zero_idx);
        if (idx > zero_idx) begin
            return idx - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_reg64.sv
// reg64: WIDTH-bit register with synchronous active-high reset and load enable.
// Ports: clk, reset, en_i (load), d_i (data in), q_o (stored value).
module reg64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    // Reset wins over a load presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/regfile.sv
// regfile: NREGS x WIDTH register file, one write port, two combinational read ports.
// Ports: clk, reset (sync, active-high), RegWrite/WriteRegister/WriteData (write),
//        ReadRegister1/2 -> ReadData1/2 (reads). Index ZERO_REG reads 0, writes dropped.
module regfile #(
    parameter int WIDTH    = regfile_pkg::WIDTH,
    parameter int NREGS    = regfile_pkg::NREGS,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    import regfile_pkg::*;

    // Only NREGS-1 registers are stored; the zero register is implied.
    localparam int NSTORE = NREGS - 1;

    logic [NSTORE-1:0] we_slot;
    logic [WIDTH-1:0]  slot_q [NSTORE];

    // One-hot write decode gated by RegWrite. The zero index never gets
    // an enable, so writes to it vanish without touching anything else.
    always_comb begin
        we_slot = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i != ZERO_REG && RegWrite &&
                WriteRegister == ADDR_W'(i)) begin
                we_slot[slot_of(i, ZERO_REG)] = 1'b1;
            end
        end
    end

    for (genvar s = 0; s < NSTORE; s++) begin : g_reg
        reg64 #(
            .WIDTH(WIDTH)
        ) u_reg (
            .clk  (clk),
            .reset(reset),
            .en_i (we_slot[s]),
            .d_i  (WriteData),
            .q_o  (slot_q[s])
        );
    end

    // Read muxes: no bypass, so a same-cycle write shows up after the edge.
    always_comb begin
        ReadData1 = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i != ZERO_REG && ReadRegister1 == ADDR_W'(i)) begin
                ReadData1 = slot_q[slot_of(i, ZERO_REG)];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i != ZERO_REG && ReadRegister2 == ADDR_W'(i)) begin
                ReadData2 = slot_q[slot_of(i, ZERO_REG)];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile.
// Vector table plus hand-written sequences; expectations go through a scoreboard queue.
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    regfile dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
    } vec_t;

    typedef struct {
        int          port;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb [$];
    vec_t        tbl [$];
    logic [63:0] model [32];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [63:0] model_rd(input logic [4:0] ra);
        if (ra == 5'd31) return 64'h0;
        return model[ra];
    endfunction

    task automatic drain();
        exp_t        e;
        logic [63:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = (e.port == 1) ? ReadData1 : ReadData2;
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, act, e.exp);
            end
        end
    endtask

    task automatic push_reads(input vec_t v, input string tag);
        sb.push_back('{1, model_rd(v.ra1), $sformatf("%s p1 r%0d", tag, v.ra1)});
        sb.push_back('{2, model_rd(v.ra2), $sformatf("%s p2 r%0d", tag, v.ra2)});
    endtask

    // One clock: check reads before the edge (old state), update the
    // model, then check again just after the edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        reset         = v.rst;
        RegWrite      = v.we;
        WriteRegister = v.wa;
        WriteData     = v.wd;
        ReadRegister1 = v.ra1;
        ReadRegister2 = v.ra2;
        #1;
        push_reads(v, {tag, " pre"});
        drain();
        if (v.rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (v.we && v.wa != 5'd31) begin
            model[v.wa] = v.wd;
        end
        @(posedge clk);
        #1;
        push_reads(v, {tag, " post"});
        drain();
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            step('{1'b0, 1'b0, 5'(i), 64'hBAD0_0000_0000_0000, 5'(i), 5'(31 - i)}, tag);
        end
    endtask

    initial begin
        reset         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 64'h0;
        ReadRegister1 = 5'd31;
        ReadRegister2 = 5'd31;

        // Before any reset only the zero register has a defined value;
        // try a write to it first.
        step('{1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31}, "prereset_x31");

        // Reset for two cycles with a competing write to X3.
        step('{1'b1, 1'b1, 5'd3, 64'h33, 5'd31, 5'd31}, "reset1");
        step('{1'b1, 1'b1, 5'd3, 64'h33, 5'd3, 5'd3}, "reset2");
        sweep("after_reset");

        // Back-to-back writes X0..X30, reading the target on port 1.
        for (int i = 0; i < 31; i++) begin
            step('{1'b0, 1'b1, 5'(i), 64'h0123_4567_89AB_CD00 + 64'(i),
                   5'(i), 5'(i)}, "wr_seq");
        end
        sweep("readback");

        // Write to zero register must not disturb anything.
        step('{1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30}, "x31_write");
        sweep("after_x31");

        tbl.push_back('{1'b0, 1'b1, 5'd5,  64'hA5,   5'd5,  5'd31});
        tbl.push_back('{1'b0, 1'b0, 5'd5,  64'h5A,   5'd5,  5'd5});
        tbl.push_back('{1'b0, 1'b0, 5'd5,  64'h5A,   5'd5,  5'd4});
        tbl.push_back('{1'b0, 1'b1, 5'd7,  64'h11,   5'd7,  5'd5});
        tbl.push_back('{1'b0, 1'b1, 5'd7,  64'h22,   5'd7,  5'd7});
        tbl.push_back('{1'b0, 1'b1, 5'd8,  64'h88,   5'd7,  5'd8});
        tbl.push_back('{1'b0, 1'b1, 5'd8,  64'h99,   5'd8,  5'd3});
        tbl.push_back('{1'b1, 1'b1, 5'd3,  64'h33,   5'd3,  5'd8});
        tbl.push_back('{1'b0, 1'b0, 5'd3,  64'h33,   5'd3,  5'd7});
        tbl.push_back('{1'b0, 1'b1, 5'd30, 64'hDEAD_BEEF_0000_0001, 5'd30, 5'd0});
        tbl.push_back('{1'b0, 1'b1, 5'd0,  64'h8000_0000_0000_0000, 5'd0, 5'd30});
        tbl.push_back('{1'b0, 1'b0, 5'd0,  64'h0,    5'd0,  5'd0});
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k], $sformatf("vec%0d", k));
        end

        // Undefined write index with RegWrite low must not corrupt state.
        step('{1'b0, 1'b0, 5'bxxxxx, 64'hFFFF_0000_FFFF_0000, 5'd30, 5'd0}, "x_addr");
        sweep("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
